// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: CPU reset sequencing, halt detection, memory dump and checksum (optional pc-stall halt via SIM_RUN_CTRL_PC_STALL_EN)
module sim_run_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int RESET_CYCLES = 4,
  parameter int MAX_CYCLES = 500,
  parameter logic [ADDR_WIDTH-1:0] HALT_ADDR = {ADDR_WIDTH{1'b1}},
  parameter int DRAIN_CYCLES = 4,
  parameter logic [ADDR_WIDTH-1:0] DUMP_BASE = '0,
  parameter int DUMP_WORDS = 256
`ifdef SIM_RUN_CTRL_PC_STALL_EN
  , parameter int STALL_CYCLES = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] expected_sum,
  input  logic                  snoop_we,
  input  logic [ADDR_WIDTH-1:0] snoop_addr,
  input  logic [DATA_WIDTH-1:0] snoop_wdata,
  input  logic [DATA_WIDTH-1:0] pc,
  output logic                  cpu_reset,
  output logic                  dump_rd_en,
  output logic [ADDR_WIDTH-1:0] dump_addr,
  input  logic [DATA_WIDTH-1:0] dump_rd_data,
  output logic                  dump_valid,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic [ADDR_WIDTH-1:0] dump_index,
  output logic [31:0]           cycle_count,
  output logic [DATA_WIDTH-1:0] halt_code,
  output logic [DATA_WIDTH-1:0] checksum,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout
);
  typedef enum logic [2:0] {S_HOLD, S_RUN, S_DRAIN, S_DUMP, S_DONE} state_t;
  state_t state, state_nxt;
  logic [31:0] cnt;
  logic mbox, stall, tmo, run_end;
  logic [DATA_WIDTH-1:0] sum_nxt;
  assign mbox = snoop_we && snoop_addr == HALT_ADDR;
  assign tmo = cycle_count >= 32'(MAX_CYCLES - 1);
  assign run_end = mbox || stall || tmo;
  assign sum_nxt = {checksum[DATA_WIDTH-2:0], checksum[DATA_WIDTH-1]} + dump_rd_data;
`ifdef SIM_RUN_CTRL_PC_STALL_EN
  logic [DATA_WIDTH-1:0] last_pc;
  logic [31:0] same_cnt, same_nxt;
  assign same_nxt = (cycle_count != '0 && pc == last_pc) ? same_cnt + 32'd1 : 32'd1;
  assign stall = same_nxt >= 32'(STALL_CYCLES);
`else
  assign stall = 1'b0;
`endif
  // State register; reset returns to HOLD immediately
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_HOLD;
    else state <= state_nxt;
  // Next-state sequencing and state-decoded outputs
  always_comb begin
    state_nxt = state;
    cpu_reset = state == S_HOLD;
    done = state == S_DONE;
    dump_rd_en = state == S_DUMP && cnt < 32'(DUMP_WORDS);
    dump_addr = dump_rd_en ? DUMP_BASE + cnt[ADDR_WIDTH-1:0] : '0;
    dump_data = dump_valid ? dump_rd_data : '0;
    unique case (state)
      S_HOLD:  state_nxt = cnt == 32'(RESET_CYCLES - 1) ? S_RUN : S_HOLD;
      S_RUN:   state_nxt = run_end ? (DRAIN_CYCLES == 0 ? S_DUMP : S_DRAIN) : S_RUN;
      S_DRAIN: state_nxt = cnt == 32'(DRAIN_CYCLES - 1) ? S_DUMP : S_DRAIN;
      S_DUMP:  state_nxt = cnt == 32'(DUMP_WORDS) ? S_DONE : S_DUMP;
      default: state_nxt = S_DONE;
    endcase
  end
  // Phase counter, run statistics, dump pipeline and final verdict
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      cycle_count <= '0;
      halt_code <= '0;
      timeout <= 1'b0;
      dump_valid <= 1'b0;
      dump_index <= '0;
      checksum <= '0;
      pass <= 1'b0;
`ifdef SIM_RUN_CTRL_PC_STALL_EN
      last_pc <= '0;
      same_cnt <= '0;
`endif
    end else begin
      cnt <= state_nxt != state ? 32'd0 : cnt + 32'd1;
      if (state == S_RUN) begin
        cycle_count <= cycle_count != '1 ? cycle_count + 32'd1 : cycle_count;
        halt_code <= mbox ? snoop_wdata : stall ? pc : halt_code;
        timeout <= !mbox && !stall && tmo;
`ifdef SIM_RUN_CTRL_PC_STALL_EN
        last_pc <= pc;
        same_cnt <= same_nxt;
`endif
      end
      dump_valid <= dump_rd_en;
      dump_index <= dump_addr;
      if (dump_valid) checksum <= sum_nxt;
      if (state == S_DUMP && state_nxt == S_DONE) pass <= !timeout && sum_nxt == expected_sum;
    end
endmodule
